// File: rtl/clock_pkg.sv
// clock_pkg: shared definitions for the clock user-interface controller.
//   mode_t        - mode encodings driven on clock_ctrl mode output
//   BTN_*         - bit positions of the three buttons in the packed button vectors
//   *_DEF         - default prescaler and debounce lengths for a 50 MHz system clock
//   next_mode()   - mode sequence advanced by one mode-button press
package clock_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        MODE_X  = 2'd3   // unused encoding; always recovers to RUN
    } mode_t;

    localparam int unsigned BTN_MODE = 0;
    localparam int unsigned BTN_INC  = 1;
    localparam int unsigned BTN_VIEW = 2;
    localparam int unsigned NUM_BTN  = 3;

    localparam int unsigned TICK_DIV_DEF  = 50_000_000;
    localparam int unsigned DB_CYCLES_DEF = 500_000;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            RUN:     return SET_HR;
            SET_HR:  return SET_MIN;
            default: return RUN;
        endcase
    endfunction

endpackage

// File: rtl/clock_ctrl_if.sv
// clock_ctrl_if: button inputs and clock-block control outputs of clock_ctrl.
//   btn_mode/btn_inc/btn_view - raw asynchronous push-buttons, active-high
//   en_sec   - one-cycle seconds tick
//   sel_min  - 1: minutes count from seconds carry, 0: minutes take set
//   sel_hr   - 1: hours count from minutes carry, 0: hours take set
//   set      - one-cycle increment pulse for the field being set
//   state    - display select, 1 = hh:mm, 0 = mm:ss
//   mode     - current mode for display blanking/blink
// master: the controller; slave: the buttons/clock side.
interface clock_ctrl_if;
    import clock_pkg::*;

    logic  btn_mode;
    logic  btn_inc;
    logic  btn_view;
    logic  en_sec;
    logic  sel_min;
    logic  sel_hr;
    logic  set;
    logic  state;
    mode_t mode;

    modport master (
        input  btn_mode, btn_inc, btn_view,
        output en_sec, sel_min, sel_hr, set, state, mode
    );

    modport slave (
        output btn_mode, btn_inc, btn_view,
        input  en_sec, sel_min, sel_hr, set, state, mode
    );

endinterface

// File: rtl/clock_ctrl_debouncer.sv
// debouncer: 2-flop synchroniser plus stable-count filter for one raw button.
//   clk      - system clock
//   rst      - asynchronous active-low reset
//   btn_raw  - raw asynchronous button level
//   press    - registered one-cycle pulse on each accepted rising level
// A new level is accepted after DB_CYCLES consecutive synchronised samples
// that differ from the current accepted level; any agreeing sample restarts
// the count. Releases update the level silently.
module debouncer
    import clock_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned    CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;
    logic          differ;

    assign differ = sync_q[1] != level_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
            press  <= 1'b0;
            if (!differ) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                // Press pulse is produced on the same edge the level is
                // accepted, so downstream registers see it one edge later.
                level_q <= sync_q[1];
                cnt_q   <= '0;
                press   <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_ctrl.sv
// clock_ctrl: user-interface controller for the clock time-keeping block.
//   clk  - system clock, all state on the rising edge
//   rst  - asynchronous active-low reset
//   bus  - clock_ctrl_if.master: raw buttons in, registered clock controls out
// Generates the 1 Hz seconds tick, debounces three buttons and runs the
// RUN -> SET_HR -> SET_MIN -> RUN mode machine. Every output is registered.
module clock_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic         clk,
    input  logic         rst,
    clock_ctrl_if.master bus
);

    localparam int unsigned   PW      = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] press;

    assign btn_raw[BTN_MODE] = bus.btn_mode;
    assign btn_raw[BTN_INC]  = bus.btn_inc;
    assign btn_raw[BTN_VIEW] = bus.btn_view;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        debouncer #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk     (clk),
            .rst     (rst),
            .btn_raw (btn_raw[i]),
            .press   (press[i])
        );
    end

    mode_t         mode_q,    mode_n;
    logic          view_q,    view_n;     // display select remembered for RUN
    logic [PW-1:0] presc_q,   presc_n;
    logic          en_sec_q,  en_sec_n;
    logic          sel_min_q, sel_min_n;
    logic          sel_hr_q,  sel_hr_n;
    logic          set_q,     set_n;
    logic          state_q,   state_n;
    logic          run_stay;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q    <= RUN;
            view_q    <= 1'b1;
            presc_q   <= '0;
            en_sec_q  <= 1'b0;
            sel_min_q <= 1'b1;
            sel_hr_q  <= 1'b1;
            set_q     <= 1'b0;
            state_q   <= 1'b1;
        end else begin
            mode_q    <= mode_n;
            view_q    <= view_n;
            presc_q   <= presc_n;
            en_sec_q  <= en_sec_n;
            sel_min_q <= sel_min_n;
            sel_hr_q  <= sel_hr_n;
            set_q     <= set_n;
            state_q   <= state_n;
        end
    end

    always_comb begin
        mode_n   = mode_q;
        view_n   = view_q;
        set_n    = 1'b0;
        presc_n  = '0;
        en_sec_n = 1'b0;

        // A mode press wins; inc/view presses in the same cycle are dropped.
        case (mode_q)
            RUN: begin
                if (press[BTN_MODE])
                    mode_n = next_mode(mode_q);
                else if (press[BTN_VIEW])
                    view_n = ~view_q;
            end
            SET_HR, SET_MIN: begin
                if (press[BTN_MODE])
                    mode_n = next_mode(mode_q);
                else
                    set_n = press[BTN_INC];
            end
            default: mode_n = RUN;
        endcase

        // Prescaler only runs while staying in RUN; any other cycle parks it
        // at 0 so RUN entry restarts the full TICK_DIV period.
        run_stay = (mode_q == RUN) && (mode_n == RUN);
        if (run_stay) begin
            presc_n  = (presc_q == PRE_MAX) ? '0 : presc_q + 1'b1;
            en_sec_n = (presc_q == PRE_MAX);
        end

        sel_min_n = (mode_n != SET_MIN);
        sel_hr_n  = (mode_n != SET_HR);
        state_n   = (mode_n == RUN) ? view_n : 1'b1;
    end

    assign bus.mode    = mode_q;
    assign bus.en_sec  = en_sec_q;
    assign bus.sel_min = sel_min_q;
    assign bus.sel_hr  = sel_hr_q;
    assign bus.set     = set_q;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_clock_ctrl.sv
module tb_clock_ctrl;
    import clock_pkg::*;

    localparam int unsigned TICK = 10;
    localparam int unsigned DB   = 4;   // button latency L = DB + 3 = 7

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    clock_ctrl_if bus ();

    clock_ctrl #(.TICK_DIV(TICK), .DB_CYCLES(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int idx, input logic v);
        case (idx)
            0:       bus.btn_mode = v;
            1:       bus.btn_inc  = v;
            default: bus.btn_view = v;
        endcase
    endtask

    // Full press and release, long enough for both edges to be accepted.
    task automatic hit(input int idx);
        drive(idx, 1'b1);
        idle(7);
        drive(idx, 1'b0);
        idle(10);
    endtask

    task automatic chk_outs(input string tag, input logic sm, input logic sh,
                            input logic st, input logic [1:0] md);
        chk({tag, "_sel_min"}, bus.sel_min, sm);
        chk({tag, "_sel_hr"},  bus.sel_hr,  sh);
        chk({tag, "_state"},   bus.state,   st);
        chk({tag, "_mode"},    bus.mode,    md);
    endtask

    initial begin
        int nset;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.btn_view = 1'b0;

        // Reset values
        idle(3);
        chk("rst_en_sec", bus.en_sec, 1'b0);
        chk("rst_set",    bus.set,    1'b0);
        chk_outs("rst", 1'b1, 1'b1, 1'b1, 2'd0);

        // Free-running seconds tick: pulses after edges 10, 20, 30
        rst = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            chk($sformatf("tick_c%0d", c), bus.en_sec, (c % 10) == 0);
        end
        chk_outs("run_idle", 1'b1, 1'b1, 1'b1, 2'd0);

        // View toggles in RUN after exactly L clocks
        bus.btn_view = 1'b1;
        idle(6);
        chk("view1_pre", bus.state, 1'b1);
        idle(1);
        chk("view1", bus.state, 1'b0);
        bus.btn_view = 1'b0;
        idle(10);
        chk("view1_hold", bus.state, 1'b0);
        hit(BTN_VIEW);
        chk("view2", bus.state, 1'b1);
        hit(BTN_VIEW);
        chk("view3", bus.state, 1'b0);

        // RUN -> SET_HR: state forced to 1, seconds frozen
        bus.btn_mode = 1'b1;
        idle(6);
        chk("mode1_pre", bus.mode, 2'd0);
        idle(1);
        chk_outs("sethr", 1'b1, 1'b0, 1'b1, 2'd1);
        bus.btn_mode = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            chk("sethr_en_sec", bus.en_sec, 1'b0);
        end

        // View ignored in SET_HR
        hit(BTN_VIEW);
        chk_outs("sethr_view", 1'b1, 1'b0, 1'b1, 2'd1);

        // Two inc presses -> two single-cycle set pulses
        for (int p = 0; p < 2; p++) begin
            bus.btn_inc = 1'b1;
            idle(6);
            chk($sformatf("inc%0d_pre", p), bus.set, 1'b0);
            idle(1);
            chk($sformatf("inc%0d_set", p), bus.set, 1'b1);
            idle(1);
            chk($sformatf("inc%0d_end", p), bus.set, 1'b0);
            bus.btn_inc = 1'b0;
            idle(10);
        end

        // SET_HR -> SET_MIN
        hit(BTN_MODE);
        chk_outs("setmin", 1'b0, 1'b1, 1'b1, 2'd2);

        // Bouncing inc is filtered; a steady hold gives exactly one pulse at L
        nset = 0;
        for (int i = 0; i < 5; i++) begin
            bus.btn_inc = 1'b1;
            idle(1); nset += int'(bus.set);
            idle(1); nset += int'(bus.set);
            bus.btn_inc = 1'b0;
            idle(1); nset += int'(bus.set);
            idle(1); nset += int'(bus.set);
        end
        chk("bounce_no_set", nset, 0);
        bus.btn_inc = 1'b1;
        nset = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            nset += int'(bus.set);
            if (c == 7) chk("hold_set_at_L", bus.set, 1'b1);
        end
        chk("hold_one_set", nset, 1);
        bus.btn_inc = 1'b0;
        idle(10);

        // Mode and inc on the same edge: mode wins, state restores RUN value
        bus.btn_mode = 1'b1;
        bus.btn_inc  = 1'b1;
        idle(6);
        chk("simul_pre", bus.mode, 2'd2);
        idle(1);
        chk("simul_set", bus.set, 1'b0);
        chk_outs("simul", 1'b1, 1'b1, 1'b0, 2'd0);
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        nset = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            nset += int'(bus.set);
            chk($sformatf("reentry_c%0d", c), bus.en_sec, c == 10);
        end
        chk("simul_no_set", nset, 0);

        // Asynchronous reset in SET_MIN with an inc debounce in progress
        hit(BTN_MODE);
        hit(BTN_MODE);
        chk("pre_rst_mode", bus.mode, 2'd2);
        bus.btn_inc = 1'b1;
        idle(4);
        #2 rst = 1'b0;
        #1;
        chk("arst_en_sec", bus.en_sec, 1'b0);
        chk("arst_set",    bus.set,    1'b0);
        chk_outs("arst", 1'b1, 1'b1, 1'b1, 2'd0);
        bus.btn_inc = 1'b0;
        idle(2);
        rst = 1'b1;
        nset = 0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            nset += int'(bus.set);
            chk($sformatf("post_rst_tick_c%0d", c), bus.en_sec, c == 10);
        end
        chk("post_rst_no_set", nset, 0);
        chk("post_rst_mode", bus.mode, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clock_ctrl.md
# clock_ctrl

User-interface controller that drives the control inputs of the `clock` time-keeping block. Generates the 1 Hz seconds enable from the system clock, debounces three raw push-buttons, and runs the run/set-hours/set-minutes mode machine that steers `sel_min`, `sel_hr`, `set` and the display `state` select. Sits directly upstream of `clock`; every output connects one-to-one to the identically named `clock` input.

## Interface
- `TICK_DIV`, 50_000_000: system clock cycles per `en_sec` pulse; minimum 2.
- `DB_CYCLES`, 500_000: consecutive stable synchronised samples required before a button level is accepted; minimum 1.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `btn_mode`  in  1  raw mode button, asynchronous, active-high.
- `btn_inc`  in  1  raw increment button, asynchronous, active-high.
- `btn_view`  in  1  raw display-select button, asynchronous, active-high.
- `en_sec`  out  1  one-cycle seconds tick.
- `sel_min`  out  1  1 = minutes count from seconds carry, 0 = minutes take `set`.
- `sel_hr`  out  1  1 = hours count from minutes carry, 0 = hours take `set`.
- `set`  out  1  one-cycle increment pulse for the field being set.
- `state`  out  1  display select: 1 = hh:mm, 0 = mm:ss.
- `mode`  out  2  current mode, for display blanking/blink.

## Operation
- All outputs registered. Reset values: `en_sec`=0, `sel_min`=1, `sel_hr`=1, `set`=0, `state`=1, `mode`=RUN; prescaler 0; debounced levels 0.
- Button path, per button: 2-flop synchroniser, then debouncer. Counter clears whenever synchronised sample equals accepted level; otherwise increments; when it reaches DB_CYCLES-1 while still differing, accepted level updates and counter clears. Press = rising edge of accepted level; release ignored.
- Mode FSM (press of `btn_mode`): RUN -> SET_HR -> SET_MIN -> RUN.
  - RUN: `sel_min`=1, `sel_hr`=1, `set`=0, `state` toggled by each `btn_view` press.
  - SET_HR: `sel_hr`=0, `sel_min`=1, `state` forced 1; each `btn_inc` press gives one `set` pulse.
  - SET_MIN: `sel_min`=0, `sel_hr`=1, `state` forced 1; each `btn_inc` press gives one `set` pulse.
  - `btn_inc` ignored in RUN; `btn_view` ignored in set modes. On return to RUN, `state` restores its last RUN value.
- Prescaler: in RUN counts 0..TICK_DIV-1 and wraps; `en_sec`=1 for the single cycle following the count TICK_DIV-1. In set modes, prescaler held at 0 and `en_sec`=0 (seconds frozen). Entering RUN restarts from 0.
- Simultaneous presses: mode press wins; a same-cycle inc or view press is discarded.
- No auto-repeat; holding `btn_inc` produces exactly one `set`.

## Timing
- Button latency L = DB_CYCLES + 3 clocks from the first rising `clk` edge that samples the raw level high (2 sync, DB_CYCLES debounce, 1 output register), raw input held stable throughout. Response (`set` pulse, `state` toggle, mode outputs) appears after exactly L clocks.
- `en_sec` period exactly TICK_DIV clocks; the first pulse occurs TICK_DIV clocks after the first clock edge following reset release or RUN entry.
- Mode change and new `sel_*` values update in the same cycle.
- `set` never asserted in the same cycle as a `sel_*` change.
- Reset mid-operation: all outputs reach reset values asynchronously; the FSM re-enters RUN with no spurious pulse on release.

## Structure
- Shared package `clock_pkg`: mode encodings RUN=2'd0, SET_HR=2'd1, SET_MIN=2'd2 (2'd3 illegal, recovers to RUN), default TICK_DIV and DB_CYCLES.
- Sub-module `debouncer` (synchroniser, stable-count filter, press-pulse output, parameter DB_CYCLES), instantiated three times. FSM, prescaler and output registers live in `clock_ctrl`.

## Test plan
TICK_DIV=10, DB_CYCLES=4, L=7.
- Reset release, no buttons -> `en_sec` pulses at cycles 10, 20, 30; `sel_min`=`sel_hr`=1, `state`=1, `mode`=0 throughout.
- `btn_view` press in RUN -> `state` 1->0 at cycle L; second press -> back to 1; press in SET_HR -> no change.
- One `btn_mode` press -> `mode`=1, `sel_hr`=0, `en_sec` stays 0; two `btn_inc` presses -> exactly two one-cycle `set` pulses; second `btn_mode` press -> `mode`=2, `sel_min`=0, `sel_hr`=1.
- `btn_inc` toggling every 2 cycles for 20 cycles, then held high for 30 cycles -> exactly one `set` pulse, L cycles after the final rising edge.
- In SET_MIN, `btn_mode` and `btn_inc` rise on the same edge -> `mode`=0, no `set` pulse; first `en_sec` pulse 10 cycles later.
- `rst` asserted mid-cycle while in SET_MIN with a debounce in progress -> outputs reach reset values before the next edge; after release, no `set` pulse and `mode`=0.
